sramgen_sram_req_adapter: RTL and testbench

Valid/ready front-end placed directly upstream of the single-port 2048x32 byte-masked SRAM macro (one-cycle registered read, no handshake). It accepts read and write requests on a valid/ready stream and drives the macro's clk-domain pins. It captures read data one cycle later into a credit-protected response FIFO, so response backpressure never drops data. Writes produce no response.

---
 rtl/sramgen_sram_req_adapter.sv | 113 +++++++++++
 tb/tb_sramgen_sram_req_adapter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sramgen_sram_req_adapter.sv
// sramgen_sram_req_adapter
// Valid/ready front-end for a single-port byte-masked SRAM macro with a
// one-cycle registered read. Requests go straight through to the macro pins.
// Read data is captured one cycle after the read into a small response FIFO.
// A credit check keeps that FIFO from ever overflowing.
//
// Ports
//   clk, rst              clock shared with the macro; async active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_wmask             byte write mask (used by writes only)
//   req_addr, req_din     word address and write data
//   resp_valid/ready      read response handshake; resp_data is in request order
//   sram_we, sram_wmask   macro write enable and byte mask
//   sram_addr, sram_din   macro address and write data
//   sram_dout             macro read data (valid the cycle after a read)
module sramgen_sram_req_adapter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 11,
   parameter int WMASK_WIDTH = 4,
   parameter int RESP_DEPTH  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [WMASK_WIDTH-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]  req_din,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [DATA_WIDTH-1:0]  resp_data,
   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);

   localparam int CW = $clog2(RESP_DEPTH + 1);
   localparam int PW = $clog2(RESP_DEPTH);

   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic                  infl_q, infl_d;
   logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [RESP_DEPTH];

   logic [CW:0] used;
   logic        fire, push, pop;

   // A read holds its credit from the cycle after acceptance (infl) until it
   // is popped, so a push can never land in a full FIFO. Writes share the same
   // gate to keep request ordering simple. Only registered state feeds this.
   always_comb begin
      used      = {1'b0, count_q} + (CW+1)'(infl_q);
      req_ready = !rst && (used < (CW+1)'(RESP_DEPTH));
   end

   assign fire       = req_valid && req_ready;
   assign sram_we    = fire && req_we;
   assign sram_wmask = req_wmask;
   assign sram_addr  = req_addr;
   assign sram_din   = req_din;

   // Macro dout is valid in the cycle after the read; infl marks that cycle.
   assign push       = infl_q;
   assign resp_valid = (count_q != '0);
   assign pop        = resp_valid && resp_ready;
   assign resp_data  = mem_q[rd_ptr_q];

   always_comb begin
      infl_d   = fire && !req_we;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = sram_dout;
         wr_ptr_d = (wr_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         infl_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         infl_q   <= infl_d;
      end
   end

   // Storage needs no reset: nothing reads it while count is zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_sramgen_sram_req_adapter.sv
module tb_sramgen_sram_req_adapter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [3:0]  req_wmask;
   logic [10:0] req_addr;
   logic [31:0] req_din;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic        sram_we;
   logic [3:0]  sram_wmask;
   logic [10:0] sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   sramgen_sram_req_adapter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_wmask(req_wmask), .req_addr(req_addr), .req_din(req_din),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // Behavioural macro: byte-masked write, one-cycle registered read.
   logic [31:0] sram_mem [2048];
   always_ff @(posedge clk) begin
      if (sram_we)
         for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      sram_dout <= sram_mem[sram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      else
         pass_cnt++;
   endtask

   task automatic drive(input logic v, input logic we, input logic [3:0] m,
                        input logic [10:0] a, input logic [31:0] d, input logic rr);
      @(posedge clk); #1;
      req_valid = v; req_we = we; req_wmask = m; req_addr = a; req_din = d;
      resp_ready = rr;
   endtask

   typedef struct {
      logic        vld;
      logic        we;
      logic [3:0]  mask;
      logic [10:0] addr;
      logic [31:0] din;
      logic        rr;
      logic        e_rdy;
      logic        e_we;
      logic        e_rv;
      logic [31:0] e_data;
   } vec_t;

   vec_t vt [13];

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ref_mem [8];
      logic [31:0] q [$];
      int fires;
      logic [31:0] w;

      // write-then-read, masked writes, zero-mask write
      vt[0]  = '{1'b1, 1'b1, 4'hF, 11'h005, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
      vt[1]  = '{1'b1, 1'b0, 4'h0, 11'h005, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[2]  = '{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[3]  = '{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
      vt[4]  = '{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[5]  = '{1'b1, 1'b1, 4'hF, 11'h010, 32'h11223344, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
      vt[6]  = '{1'b1, 1'b1, 4'h5, 11'h010, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
      vt[7]  = '{1'b1, 1'b0, 4'h0, 11'h010, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[8]  = '{1'b1, 1'b1, 4'h0, 11'h010, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
      vt[9]  = '{1'b1, 1'b0, 4'h0, 11'h010, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h11BB33DD};
      vt[10] = '{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[11] = '{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h11BB33DD};
      vt[12] = '{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

      rst = 1'b1; req_valid = 0; req_we = 0; req_wmask = 0; req_addr = 0; req_din = 0;
      resp_ready = 0;

      // reset state
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_sram_we", 32'(sram_we), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // table vectors
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].vld, vt[i].we, vt[i].mask, vt[i].addr, vt[i].din, vt[i].rr);
         @(negedge clk);
         chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vt[i].e_rdy));
         chk($sformatf("vec%0d_sram_we", i), 32'(sram_we), 32'(vt[i].e_we));
         chk($sformatf("vec%0d_resp_valid", i), 32'(resp_valid), 32'(vt[i].e_rv));
         if (vt[i].e_rv) chk($sformatf("vec%0d_resp_data", i), resp_data, vt[i].e_data);
      end

      // back-to-back: preload addr i = i*3, then 16 reads with resp_ready high
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 4'hF, 11'(i), 32'(i * 3), 1'b1);
         @(negedge clk);
         chk("preload_ready", 32'(req_ready), 32'd1);
      end
      for (int i = 0; i < 18; i++) begin
         drive(i < 16, 1'b0, 4'h0, 11'(i), 32'h0, 1'b1);
         @(negedge clk);
         if (i < 16) chk($sformatf("b2b_ready%0d", i), 32'(req_ready), 32'd1);
         if (i >= 2) begin
            chk($sformatf("b2b_rv%0d", i), 32'(resp_valid), 32'd1);
            chk($sformatf("b2b_data%0d", i), resp_data, 32'((i - 2) * 3));
         end
      end
      drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk("b2b_rv_end", 32'(resp_valid), 32'd0);

      // credit exhaustion with resp_ready low
      fires = 0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'b0, 4'h0, 11'(fires), 32'h0, 1'b0);
         @(negedge clk);
         if (req_valid && req_ready) fires++;
      end
      chk("stall_fires", 32'(fires), 32'd3);
      chk("stall_ready", 32'(req_ready), 32'd0);
      drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk("drain0_rv", 32'(resp_valid), 32'd1);
      chk("drain0_data", resp_data, 32'd0);
      chk("drain0_ready", 32'(req_ready), 32'd0);
      drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk("drain1_ready", 32'(req_ready), 32'd1);
      chk("drain1_data", resp_data, 32'd3);
      drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk("drain2_data", resp_data, 32'd6);
      drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk("drain3_rv", 32'(resp_valid), 32'd0);

      // reset with a read in flight
      drive(1'b1, 1'b0, 4'h0, 11'h005, 32'h0, 1'b1);
      @(negedge clk);
      chk("rstfl_fire", 32'(req_ready), 32'd1);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF; req_din = 32'h0;
         @(negedge clk);
         chk("rstfl_ready", 32'(req_ready), 32'd0);
         chk("rstfl_rv", 32'(resp_valid), 32'd0);
         chk("rstfl_we", 32'(sram_we), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("rstfl_ready_after", 32'(req_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b1);
         @(negedge clk);
         chk("rstfl_no_resp", 32'(resp_valid), 32'd0);
      end

      // random traffic against a scoreboard
      for (int a = 0; a < 8; a++) ref_mem[a] = 32'(a * 3);
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
               11'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
         @(negedge clk);
         chk("rnd_ready", 32'(req_ready), 32'(q.size() < 3));
         if (resp_valid && resp_ready) begin
            chk("rnd_q_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) chk("rnd_data", resp_data, q.pop_front());
         end
         if (req_valid && req_ready) begin
            if (req_we) begin
               w = ref_mem[req_addr[2:0]];
               for (int b = 0; b < 4; b++)
                  if (req_wmask[b]) w[b*8 +: 8] = req_din[b*8 +: 8];
               ref_mem[req_addr[2:0]] = w;
            end else begin
               q.push_back(ref_mem[req_addr[2:0]]);
            end
         end
      end
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b1);
         @(negedge clk);
         if (resp_valid) begin
            chk("drain_q_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) chk("drain_data", resp_data, q.pop_front());
         end
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
      chk("drain_rv", 32'(resp_valid), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
